// File: rtl/alu_hs_param_if.sv
// Operand/result handshake bundle for alu_hs_param.
// Two valid/ready channels: operation in, result out.
interface alu_hs_param_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_err
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_err
    );
endinterface

// File: rtl/alu_hs_param.sv
// Handshaked WIDTH-bit ALU: 1-cycle ops plus a WIDTH-step restoring divider for DIVU/REMU.
// Define ALU_MUL_EN to build the multiplier for opcode 8; otherwise opcode 8 reports err.
module alu_hs_param #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_hs_param_if.slave bus,
    output logic          busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SRA = 4'd7,
                           OP_MUL = 4'd8, OP_DIVU = 4'd9, OP_REMU = 4'd10;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             isrem_q, isrem_d;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   sh;
    logic             acc, start_div;

    assign a  = bus.in_a;
    assign b  = bus.in_b;
    assign sh = b[SHW-1:0];

    assign bus.in_ready   = !rst && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;
    assign bus.out_err    = err_q;
    assign busy           = (state_q != IDLE);

    assign acc       = bus.in_valid && bus.in_ready;
    assign start_div = (bus.in_op == OP_DIVU || bus.in_op == OP_REMU) && (b != '0);

    // Shifts carry one extra bit so the last bit shifted out lands in the spare position.
    logic [WIDTH:0]   add_ext, shl_ext, shr_ext, sra_ext;
    logic [WIDTH-1:0] sub_r;
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_r   = a - b;
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v, alu_e;
    logic [3:0]       alu_flags;

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_e = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                alu_r = add_ext[WIDTH-1:0];
                alu_c = add_ext[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_r;
                alu_c = (a < b);
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_SHL: begin alu_r = shl_ext[WIDTH-1:0]; alu_c = shl_ext[WIDTH]; end
            OP_SHR: begin alu_r = shr_ext[WIDTH:1];   alu_c = shr_ext[0];     end
            OP_SRA: begin alu_r = sra_ext[WIDTH:1];   alu_c = sra_ext[0];     end
`ifdef ALU_MUL_EN
            OP_MUL: begin alu_r = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; end
`endif
            // Non-zero divisors go to the divider; only the b==0 case lands here.
            OP_DIVU: begin alu_r = '1; alu_e = 1'b1; end
            OP_REMU: begin alu_r = a;  alu_e = 1'b1; end
            default: alu_e = 1'b1;
        endcase
    end

    assign alu_flags = {alu_r == '0, alu_r[WIDTH-1], alu_c, alu_v};

    // One restoring step: remainder is always < divisor, so bit WIDTH of the difference is its sign.
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] step_q, step_r, div_res;
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign step_q   = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    assign step_r   = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    assign div_res  = isrem_q ? step_r : step_q;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        isrem_d = isrem_q;
        case (state_q)
            DIV: begin
                quo_d = step_q;
                rem_d = step_r;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    res_d   = div_res;
                    flags_d = {div_res == '0, div_res[WIDTH-1], 2'b00};
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: ;
        endcase
        if (acc) begin
            if (start_div) begin
                quo_d   = a;
                rem_d   = '0;
                dvs_d   = b;
                cnt_d   = CW'(WIDTH);
                isrem_d = (bus.in_op == OP_REMU);
                state_d = DIV;
            end else begin
                res_d   = alu_r;
                flags_d = alu_flags;
                err_d   = alu_e;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            isrem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            isrem_q <= isrem_d;
        end
    end
endmodule

// File: tb/tb_alu_hs_param.sv
// Bench for alu_hs_param at WIDTH=8: directed cases then random ops against an arithmetic model.
module tb_alu_hs_param;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    alu_hs_param_if #(.WIDTH(W)) bus ();
    alu_hs_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {err, Z, N, C, V, result} from the opcode rules using plain integer arithmetic.
    function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] a8, input logic [W-1:0] b8);
        longint M, H, a, b, sa, sb, s, r, p;
        int sh;
        logic c, v, e;
        M = longint'(1) << W;
        H = longint'(1) << (W - 1);
        a = longint'(a8);
        b = longint'(b8);
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        sh = int'(b % W);
        c = 1'b0; v = 1'b0; e = 1'b0; r = 0;
        case (op)
            4'd0: begin s = a + b; r = s % M; c = (s >= M); s = sa + sb; v = (s >= H) || (s < -H); end
            4'd1: begin r = (a - b + M) % M; c = (a < b); s = sa - sb; v = (s >= H) || (s < -H); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = (a << sh) % M; c = (sh != 0) && (((a >> (W - sh)) & 1) == 1); end
            4'd6: begin r = a >> sh;       c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            4'd7: begin r = (sa >>> sh) & (M - 1); c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
`ifdef ALU_MUL_EN
            4'd8: begin p = a * b; r = p % M; c = (p >= M); end
`endif
            4'd9:  if (b == 0) begin r = M - 1; e = 1'b1; end else r = a / b;
            4'd10: if (b == 0) begin r = a;     e = 1'b1; end else r = a % b;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, (r == 0), (r >= H), c, v, r[W-1:0]};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        // Scramble operands after the accept edge; the block must not look at them again.
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        bus.in_op    = 4'($urandom);
    endtask

    // Issue one op, check accept, latency, result/flags/err, then hold out_ready low for 'stall' cycles.
    task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall, output int waited);
        logic [W+4:0] exp;
        int lat, exp_lat;
        exp     = model(op, a, b);
        exp_lat = ((op == 4'd9 || op == 4'd10) && b != '0) ? W : 0;
        issue(op, a, b, waited);
        chk({tag, "_accept"}, 32'(waited < 200), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_valid"},   32'(bus.out_valid), 32'd1);
        chk({tag, "_result"},  32'(bus.out_result), 32'(exp[W-1:0]));
        chk({tag, "_flags"},   32'(bus.out_flags), 32'(exp[W+3:W]));
        chk({tag, "_err"},     32'(bus.out_err), 32'(exp[W+4]));
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                chk({tag, "_hold_result"}, 32'(bus.out_result), 32'(exp[W-1:0]));
                chk({tag, "_hold_flags"}, 32'(bus.out_flags), 32'(exp[W+3:W]));
                chk({tag, "_hold_inready"}, 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
        end
    endtask

    initial begin
        int w;
        logic [3:0] op;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.out_result), 32'd0);
        chk("rst_flags", 32'(bus.out_flags), 32'd0);
        chk("rst_err", 32'(bus.out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        run("add_ff_01", 4'd0, 8'hFF, 8'h01, 0, w);
        chk("add_ff_01_const", {bus.out_flags, bus.out_result}, {4'b1010, 8'h00});
        run("sub_80_01", 4'd1, 8'h80, 8'h01, 0, w);
        chk("sub_80_01_const", {bus.out_flags, bus.out_result}, {4'b0001, 8'h7F});
        run("sub_01_02", 4'd1, 8'h01, 8'h02, 0, w);
        chk("sub_01_02_const", {bus.out_flags, bus.out_result}, {4'b0110, 8'hFF});
        run("divu_200_7", 4'd9, 8'd200, 8'd7, 0, w);
        chk("divu_200_7_const", 32'(bus.out_result), 32'd28);
        run("remu_200_7", 4'd10, 8'd200, 8'd7, 0, w);
        chk("remu_200_7_const", 32'(bus.out_result), 32'd4);
        run("divu_by0", 4'd9, 8'h55, 8'h00, 0, w);
        chk("divu_by0_const", {bus.out_err, bus.out_result}, {1'b1, 8'hFF});
        run("remu_by0", 4'd10, 8'h55, 8'h00, 0, w);
        run("mul_10_10", 4'd8, 8'h10, 8'h10, 0, w);
        for (int i = 11; i < 16; i++) run("illegal", 4'(i), 8'h3C, 8'h5A, 0, w);
        run("sra_neg", 4'd7, 8'h81, 8'h01, 0, w);
        run("shl_sh0", 4'd5, 8'hA5, 8'h08, 0, w);
        @(posedge clk);
        #1;
        chk("drain_idle_busy", 32'(busy), 32'd0);
        chk("drain_idle_valid", 32'(bus.out_valid), 32'd0);

        run("bp_add", 4'd0, 8'h12, 8'h34, 3, w);
        run("bp_xor", 4'd4, 8'hF0, 8'h0F, 0, w);
        chk("bp_xor_same_edge", 32'(w), 32'd0);
        chk("bp_xor_const", 32'(bus.out_result), 32'hFF);

        for (int i = 0; i < 4; i++) begin
            run("stream", 4'(i), 8'(8'h31 * (i + 1)), 8'(8'h17 + i), 0, w);
            chk("stream_no_wait", 32'(w), 32'd0);
        end

        issue(4'd9, 8'd200, 8'd7, w);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_div_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_div_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("rst_mid_div_no_pulse", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run("rand", op, ra, rb, int'($urandom_range(0, 2)), w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
